// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Accepts operand vectors over valid/ready and drives them onto
//               diagonally skewed weight/activation buses for a systolic array.
//               After each tile it flushes zeros and then pulses tile_done.
//               Optional statistics outputs are enabled by FEEDER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
    parameter int SIZE      = 4,
    parameter int MAX_BEATS = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*SIZE-1:0]    s_weight,
    input  logic [8*SIZE-1:0]    s_in,
    input  logic                 s_last,
    output logic [8*SIZE-1:0]    weight,
    output logic [8*SIZE-1:0]    in,
    output logic                 busy,
    output logic                 tile_done,
    output logic                 overflow
`ifdef FEEDER_STATS_EN
    ,
    output logic [$clog2(MAX_BEATS+1)-1:0] tile_beats,
    output logic [15:0]                    bubble_cnt
`endif
);

    localparam int c_BW          = $clog2(MAX_BEATS + 1);
    localparam int c_FW          = (2 * SIZE > 2) ? $clog2(2 * SIZE) : 1;
    localparam int c_FLUSH_LAST  = 2 * SIZE - 2;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_FLUSH  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_beat_cnt;
    logic [c_FW-1:0] r_flush_cnt;
    logic            r_tile_done;
    logic            r_overflow;

    logic            w_accept;
    logic [c_BW-1:0] w_beat_next;
    logic            w_cap_hit;
    logic            w_end;
    logic            w_flush_last;

    assign s_ready      = (r_state == c_IDLE) || (r_state == c_STREAM);
    assign w_accept     = s_valid && s_ready;
    assign w_beat_next  = (r_state == c_IDLE) ? c_BW'(1) : r_beat_cnt + c_BW'(1);
    assign w_cap_hit    = (w_beat_next == c_BW'(MAX_BEATS));
    assign w_end        = w_accept && (s_last || w_cap_hit);
    assign w_flush_last = (r_flush_cnt == c_FW'(c_FLUSH_LAST));

    assign busy      = (r_state == c_STREAM) || (r_state == c_FLUSH);
    assign tile_done = r_tile_done;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_tile_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            case (r_state)
                c_IDLE, c_STREAM: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_beat_next;
                        if (w_end) begin
                            r_state     <= c_FLUSH;
                            r_flush_cnt <= '0;
                            // A tile closed by s_last is legitimate even at the cap.
                            if (!s_last) begin
                                r_overflow <= 1'b1;
                            end
                        end else begin
                            r_state <= c_STREAM;
                        end
                    end
                end
                c_FLUSH: begin
                    if (w_flush_last) begin
                        r_state     <= c_DONE;
                        r_tile_done <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_FW'(1);
                    end
                end
                c_DONE: begin
                    r_state     <= c_IDLE;
                    r_beat_cnt  <= '0;
                    r_flush_cnt <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Lane i is an (i+1)-deep chain; idle cycles push zeros so the chain never stalls.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        logic [7:0] r_wsr [0:gi];
        logic [7:0] r_isr [0:gi];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= gi; j++) begin
                    r_wsr[j] <= 8'h00;
                    r_isr[j] <= 8'h00;
                end
            end else begin
                r_wsr[0] <= w_accept ? s_weight[8*gi +: 8] : 8'h00;
                r_isr[0] <= w_accept ? s_in[8*gi +: 8]     : 8'h00;
                for (int j = 1; j <= gi; j++) begin
                    r_wsr[j] <= r_wsr[j-1];
                    r_isr[j] <= r_isr[j-1];
                end
            end
        end

        assign weight[8*gi +: 8] = r_wsr[gi];
        assign in[8*gi +: 8]     = r_isr[gi];
    end

`ifdef FEEDER_STATS_EN
    logic [c_BW-1:0] r_tile_beats;
    logic [15:0]     r_bubble_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tile_beats <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_state == c_FLUSH && w_flush_last) begin
                r_tile_beats <= r_beat_cnt;
            end
            if (r_state == c_IDLE && w_accept && !w_end) begin
                r_bubble_cnt <= '0;
            end else if (r_state == c_STREAM && !w_accept && r_bubble_cnt != 16'hFFFF) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign tile_beats = r_tile_beats;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
